// File: rtl/bus_pkg.sv
// Shared types for the 8088-style bus cycle controller.
// State width grows by one when BUSCTL_READY_EN adds the wait state.
package bus_pkg;

`ifdef BUSCTL_READY_EN
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_T1   = 6'b000010,
    S_T2   = 6'b000100,
    S_T3   = 6'b001000,
    S_T4   = 6'b010000,
    S_TW   = 6'b100000
  } bus_state_e;
`else
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_T1   = 5'b00010,
    S_T2   = 5'b00100,
    S_T3   = 5'b01000,
    S_T4   = 5'b10000
  } bus_state_e;
`endif

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        iom;
    logic        port;
  } bus_cyc_t;

  localparam int CS_MEM0 = 0;
  localparam int CS_MEM1 = 1;
  localparam int CS_IO0  = 2;
  localparam int CS_IO1  = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-port arbiter: round-robin on a last-grant pointer, or fixed priority
// (port 0 wins) when ARB_RR = 0. Pointer resets to port 1 so port 0 wins first.
module rr_arb2 #(
  parameter bit ARB_RR = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       win,
  output logic       any
);

  logic last;

  always_comb begin
    any = |req;
    if (req == 2'b11) win = ARB_RR ? ~last : 1'b0;
    else              win = req[1];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)            last <= 1'b1;
    else if (take && any) last <= win;
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus master/arbiter running one T1-T4 byte cycle per grant on the multiplexed bus.
// Optional macro BUSCTL_READY_EN adds the Ready input and the TW wait state.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter logic [11:0] IO0_BASE = 12'h000,
  parameter logic [11:0] IO1_BASE = 12'h001,
  parameter bit          ARB_RR   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef BUSCTL_READY_EN
  input  logic        Ready,
`endif
  input  logic [1:0]  Req,
  input  logic [1:0]  We,
  input  logic [1:0]  IoM,
  input  logic [19:0] Addr0,
  input  logic [19:0] Addr1,
  input  logic [7:0]  WData0,
  input  logic [7:0]  WData1,
  output logic [1:0]  Ack,
  output logic [7:0]  RData,
  output logic        Busy,
  output logic        ALE,
  output logic [11:0] A,
  inout  wire  [7:0]  AD,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic [3:0]  CS
);

  bus_state_e state, state_nxt;
  bus_cyc_t   cyc;
  logic       win, any_req, take;
  logic       addr_ph, data_ph, rd_samp, ad_oe;
  logic [7:0] ad_out;
  logic [3:0] cs_dec;

  assign take = (state == S_IDLE);

  rr_arb2 #(.ARB_RR(ARB_RR)) u_arb (
    .Clock (Clock),
    .Reset (Reset),
    .req   (Req),
    .take  (take),
    .win   (win),
    .any   (any_req)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Requester inputs are only looked at in the arbitration cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cyc <= '0;
    end else if (take && any_req) begin
      cyc.addr  <= win ? Addr1  : Addr0;
      cyc.wdata <= win ? WData1 : WData0;
      cyc.we    <= We[win];
      cyc.iom   <= IoM[win];
      cyc.port  <= win;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        RData <= '0;
    else if (rd_samp) RData <= AD;
  end

  // IO0 has priority when both bases match; an IO miss leaves CS all zero.
  always_comb begin
    cs_dec = '0;
    if (!cyc.iom) begin
      if (cyc.addr[19]) cs_dec[CS_MEM1] = 1'b1;
      else              cs_dec[CS_MEM0] = 1'b1;
    end else if (cyc.addr[15:4] == IO0_BASE) begin
      cs_dec[CS_IO0] = 1'b1;
    end else if (cyc.addr[15:4] == IO1_BASE) begin
      cs_dec[CS_IO1] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_ph   = 1'b0;
    data_ph   = 1'b0;
    ALE       = 1'b0;
    RD        = 1'b0;
    WR        = 1'b0;
    IOM       = 1'b0;
    CS        = '0;
    A         = '0;
    Ack       = '0;
    Busy      = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = cyc.addr[7:0];
    unique case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (any_req) state_nxt = S_T1;
      end
      S_T1: begin
        ALE       = 1'b1;
        addr_ph   = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        addr_ph   = 1'b1;
        RD        = ~cyc.we;
        WR        = cyc.we;
        state_nxt = S_T3;
      end
`ifdef BUSCTL_READY_EN
      S_T3, S_TW: begin
        data_ph   = 1'b1;
        state_nxt = Ready ? S_T4 : S_TW;
      end
`else
      S_T3: begin
        data_ph   = 1'b1;
        state_nxt = S_T4;
      end
`endif
      S_T4: begin
        Ack       = cyc.port ? 2'b10 : 2'b01;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (addr_ph || data_ph) begin
      A   = cyc.addr[19:8];
      IOM = cyc.iom;
      CS  = cs_dec;
    end
    if (addr_ph) ad_oe = 1'b1;
    if (data_ph) begin
      RD     = ~cyc.we;
      WR     = cyc.we;
      ad_oe  = cyc.we;
      ad_out = cyc.wdata;
    end
  end

  assign rd_samp = data_ph & ~cyc.we;
  assign AD      = ad_oe ? ad_out : 'z;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: directed bus cycles, reset abort, arbitration and
// random traffic against a transaction-level model of the bus protocol.
module tb_bus_cycle_ctrl;

  localparam logic [11:0] IO0 = 12'h000;
  localparam logic [11:0] IO1 = 12'h001;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Req = '0, We = '0, IoM = '0;
  logic [19:0] Addr0 = '0, Addr1 = '0;
  logic [7:0]  WData0 = '0, WData1 = '0;
  logic [1:0]  Ack, Ack_fp;
  logic [7:0]  RData, RData_fp;
  logic        Busy, ALE, RD, WR, IOM;
  logic        Busy_fp, ALE_fp, RD_fp, WR_fp, IOM_fp;
  logic [11:0] A, A_fp;
  logic [3:0]  CS, CS_fp;
  wire  [7:0]  AD, AD_fp;
  logic        slv_oe = 1'b0;
  logic [7:0]  slv_data = '0;
`ifdef BUSCTL_READY_EN
  logic        Ready = 1'b1;
`endif

  assign AD = slv_oe ? slv_data : 'z;

  always #5 Clock = ~Clock;

  bus_cycle_ctrl #(.IO0_BASE(IO0), .IO1_BASE(IO1), .ARB_RR(1'b1)) dut (
    .Clock(Clock), .Reset(Reset),
`ifdef BUSCTL_READY_EN
    .Ready(Ready),
`endif
    .Req(Req), .We(We), .IoM(IoM), .Addr0(Addr0), .Addr1(Addr1),
    .WData0(WData0), .WData1(WData1), .Ack(Ack), .RData(RData), .Busy(Busy),
    .ALE(ALE), .A(A), .AD(AD), .RD(RD), .WR(WR), .IOM(IOM), .CS(CS)
  );

  bus_cycle_ctrl #(.IO0_BASE(IO0), .IO1_BASE(IO1), .ARB_RR(1'b0)) dut_fp (
    .Clock(Clock), .Reset(Reset),
`ifdef BUSCTL_READY_EN
    .Ready(Ready),
`endif
    .Req(Req), .We(We), .IoM(IoM), .Addr0(Addr0), .Addr1(Addr1),
    .WData0(WData0), .WData1(WData1), .Ack(Ack_fp), .RData(RData_fp), .Busy(Busy_fp),
    .ALE(ALE_fp), .A(A_fp), .AD(AD_fp), .RD(RD_fp), .WR(WR_fp), .IOM(IOM_fp), .CS(CS_fp)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int          last_gnt;
  int          sel;
  logic [7:0]  exp_rdata;
  logic        pend [2];
  logic [19:0] p_addr [2];
  logic        p_we [2];
  logic        p_iom [2];
  logic [7:0]  p_wd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_ports();
    Req    = {pend[1], pend[0]};
    We     = {p_we[1], p_we[0]};
    IoM    = {p_iom[1], p_iom[0]};
    Addr0  = p_addr[0];
    Addr1  = p_addr[1];
    WData0 = p_wd[0];
    WData1 = p_wd[1];
  endtask

  function automatic int pick();
    if (pend[0] && pend[1]) return 1 - last_gnt;
    return pend[1] ? 1 : 0;
  endfunction

  function automatic logic [3:0] exp_cs(input logic [19:0] ad, input logic iom);
    if (!iom)              return ad[19] ? 4'b0010 : 4'b0001;
    if (ad[15:4] == IO0)   return 4'b0100;
    if (ad[15:4] == IO1)   return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_ack"}, Ack, 0);
    chk({tag, "_ale"}, ALE, 0);
    chk({tag, "_strb"}, {RD, WR}, 0);
    chk({tag, "_a"}, A, 0);
    chk({tag, "_cs"}, {IOM, CS}, 0);
  endtask

  // One complete bus cycle starting from IDLE with at least one port pending.
  task automatic bus_txn(input logic [7:0] sval);
    int          w;
    logic [19:0] ad;
    logic        we_, iom_;
    logic [7:0]  wd;
    logic [3:0]  cs;
    w = pick();
    last_gnt = w;
    ad = p_addr[w]; we_ = p_we[w]; iom_ = p_iom[w]; wd = p_wd[w];
    cs = exp_cs(ad, iom_);
    drive_ports();
    step();
    chk("t1_ale", ALE, 1);
    chk("t1_a", A, ad[19:8]);
    chk("t1_ad", AD, ad[7:0]);
    chk("t1_iom", IOM, iom_);
    chk("t1_cs", CS, cs);
    chk("t1_busy", Busy, 1);
    chk("t1_strb", {RD, WR, Ack}, 0);
    p_addr[w] = 20'($urandom);
    p_wd[w]   = 8'($urandom);
    drive_ports();
    step();
    chk("t2_ale", ALE, 0);
    chk("t2_ad", AD, ad[7:0]);
    chk("t2_rdwr", {RD, WR}, {~we_, we_});
    chk("t2_a", A, ad[19:8]);
    chk("t2_cs", {IOM, CS}, {iom_, cs});
    step();
    chk("t3_rdwr", {RD, WR}, {~we_, we_});
    chk("t3_a", A, ad[19:8]);
    chk("t3_cs", {IOM, CS}, {iom_, cs});
    if (we_) begin
      chk("t3_wdata", AD, wd);
    end else begin
      slv_data = sval;
      slv_oe   = (cs != 4'b0000);
    end
    step();
    slv_oe = 1'b0;
    if (!we_) exp_rdata = sval;
    chk("t4_ack", Ack, (w == 1) ? 2'b10 : 2'b01);
    chk("t4_rdata", RData, exp_rdata);
    chk("t4_busy", Busy, 1);
    chk("t4_quiet", {ALE, RD, WR, IOM, CS, A}, 0);
    pend[w] = 1'b0;
    drive_ports();
    step();
    chk_idle("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_addr[p] = '0; p_we[p] = 1'b0; p_iom[p] = 1'b0; p_wd[p] = '0;
    end
    drive_ports();
    step();
    step();
    chk_idle("rst");
    chk("rst_rdata", RData, 0);
    Reset = 1'b0;
    last_gnt = 1;
    exp_rdata = '0;

    // Memory write then memory read
    pend[0] = 1'b1; p_we[0] = 1'b1; p_iom[0] = 1'b0; p_addr[0] = 20'h0_1234; p_wd[0] = 8'hA5;
    bus_txn(8'h00);
    pend[0] = 1'b1; p_we[0] = 1'b0; p_iom[0] = 1'b0; p_addr[0] = 20'h8_00F0;
    bus_txn(8'h5C);

    // IO hit on IO1, then IO miss
    pend[1] = 1'b1; p_we[1] = 1'b1; p_iom[1] = 1'b1; p_addr[1] = 20'h0_0013; p_wd[1] = 8'h3E;
    bus_txn(8'h00);
    pend[1] = 1'b1; p_we[1] = 1'b1; p_iom[1] = 1'b1; p_addr[1] = 20'h0_0053; p_wd[1] = 8'hC1;
    bus_txn(8'h00);
    chk("wr_keeps_rdata", RData, 8'h5C);

    // Reset during T2 of a read aborts the cycle; the held request is served afterwards
    pend[0] = 1'b1; p_we[0] = 1'b0; p_iom[0] = 1'b0; p_addr[0] = 20'h0_4567;
    drive_ports();
    step();
    step();
    chk("abort_rd_before", RD, 1);
    #2 Reset = 1'b1;
    #1;
    chk_idle("abort");
    chk("abort_rdata", RData, 0);
    step();
    chk("abort_noack", Ack, 0);
    Reset = 1'b0;
    last_gnt = 1;
    exp_rdata = '0;
    bus_txn(8'h9B);

    // Both ports held requesting: round-robin alternates, fixed priority keeps port 0
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b1; p_we[p] = 1'b1; p_iom[p] = 1'b0; p_addr[p] = 20'($urandom); p_wd[p] = 8'($urandom);
    end
    drive_ports();
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("arb_rr_ack", Ack, (i % 5 == 4) ? (((i / 5) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk("arb_fp_ack", Ack_fp, (i % 5 == 4) ? 2'b01 : 2'b00);
      chk("arb_fp_busy", Busy_fp, (i % 5 == 0) ? 1'b0 : 1'b1);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_ports();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    last_gnt = 1;
    exp_rdata = '0;

    // Random traffic; IO reads are steered onto a decoded slave
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]   = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_iom[p]  = 1'($urandom_range(0, 1));
          p_addr[p] = 20'($urandom);
          p_wd[p]   = 8'($urandom);
          if (p_iom[p]) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)      p_addr[p][15:4] = IO0;
            else if (sel == 1) p_addr[p][15:4] = IO1;
            else               p_we[p] = 1'b1;
          end
        end
      end
      if (pend[0] || pend[1]) begin
        bus_txn(8'($urandom));
      end else begin
        drive_ports();
        step();
        chk_idle("rnd_idle");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
